alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_if.sv | 28 ++
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Handshake bundle between an operation source, the ALU op sequencer and the datapath.
// The sequencer sits on the slave side; the operation source/datapath side is the master.
interface alu_op_sequencer_if #(
  parameter int unsigned SHAMT_W = 5
) ();
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         aluop;
  logic [3:0]         funcode;
  logic [SHAMT_W-1:0] shamt;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         control;
  logic [SHAMT_W-1:0] shift_step;
  logic               last;
  logic               busy;

  modport master (
    output in_valid, aluop, funcode, shamt, flush, out_ready,
    input  in_ready, out_valid, control, shift_step, last, busy
  );

  modport slave (
    input  in_valid, aluop, funcode, shamt, flush, out_ready,
    output in_ready, out_valid, control, shift_step, last, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Decodes an ALU operation into control beats; shifts may be split into single-bit beats.
// One operation in flight at a time; all outputs come straight from registers.
module alu_op_sequencer #(
  parameter int unsigned SHAMT_W    = 5,
  parameter bit          ITER_SHIFT = 1'b1
) (
  input logic                clk,
  input logic                rst,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StShift} state_e;

  state_e             state_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] step_q;
  logic [5:0]         ctrl_q;
  logic               valid_q;
  logic               last_q;

  logic [5:0] dec;
  logic       accept;
  logic       done;
  logic       iterate;

  always_comb begin
    dec = 6'b000000;
    case (bus.aluop)
      4'b0000: begin
        case (bus.funcode)
          4'd0:    dec = 6'b000000;
          4'd1:    dec = 6'b001000;
          4'd2:    dec = 6'b010000;
          4'd3:    dec = 6'b011000;
          4'd4:    dec = 6'b101000;
          4'd5:    dec = 6'b111000;
          default: dec = 6'b110000;
        endcase
      end
      4'b0001: begin
        case (bus.funcode)
          4'd0:    dec = 6'b000000;
          4'd1:    dec = 6'b001000;
          4'd2:    dec = 6'b101000;
          4'd3:    dec = 6'b111000;
          default: dec = 6'b110000;
        endcase
      end
      4'b0100: begin
        case (bus.funcode)
          4'd0, 4'd1: dec = 6'b000110;
          4'd3:       dec = 6'b000010;
          default:    dec = 6'b000001;
        endcase
      end
      4'b0101: dec = 6'b000110;
      4'b0110: begin
        case (bus.funcode)
          4'd0:    dec = 6'b000011;
          4'd1:    dec = 6'b000100;
          4'd2:    dec = 6'b000101;
          default: dec = 6'b000000;
        endcase
      end
      default: dec = 6'b000000;
    endcase
  end

  assign accept  = bus.in_valid && (state_q == StIdle);
  assign done    = valid_q && bus.out_ready;
  // Bit 5 marks the shift class; amounts of 0 or 1 always go out as a single beat.
  assign iterate = ITER_SHIFT && dec[5] && (bus.shamt > SHAMT_W'(1));

  always_ff @(posedge clk) begin
    // Reset and flush both abandon whatever is in flight; reset is simply checked first.
    if (rst || bus.flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= '0;
      ctrl_q  <= 6'b000000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec;
            if (iterate) begin
              state_q <= StShift;
              cnt_q   <= bus.shamt;
              step_q  <= SHAMT_W'(1);
              last_q  <= 1'b0;
            end else begin
              state_q <= StIssue;
              cnt_q   <= SHAMT_W'(1);
              step_q  <= dec[5] ? bus.shamt : '0;
              last_q  <= 1'b1;
            end
          end
        end
        StIssue, StShift: begin
          if (done) begin
            if (last_q) begin
              state_q <= StIdle;
              step_q  <= '0;
              ctrl_q  <= 6'b000000;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              cnt_q  <= cnt_q - SHAMT_W'(1);
              last_q <= (cnt_q == SHAMT_W'(2));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.out_valid  = valid_q;
  assign bus.control    = ctrl_q;
  assign bus.shift_step = step_q;
  assign bus.last       = last_q;

endmodule
